alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command handshake and external 4-bit ALU bus for alu_seq.
interface alu_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_cin;
    logic       cmd_wide;
    logic       cmd_load;

    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic       alu_cin;
    logic [2:0] alu_Op;
    logic [3:0] alu_R;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_sign;

    logic [7:0] acc;
    logic       zero;
    logic       carry;
    logic       sign;
    logic       done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cin, cmd_wide, cmd_load,
        input  alu_R, alu_zero, alu_carry, alu_sign,
        output cmd_ready, alu_A, alu_B, alu_cin, alu_Op,
        output acc, zero, carry, sign, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cin, cmd_wide, cmd_load,
        output alu_R, alu_zero, alu_carry, alu_sign,
        input  cmd_ready, alu_A, alu_B, alu_cin, alu_Op,
        input  acc, zero, carry, sign, done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencer that runs 4- or 8-bit accumulator commands through an external 4-bit ALU.
// Define ALU_SEQ_WIDE_EN to enable 8-bit (two-pass) commands; otherwise cmd_wide is ignored.
//   state  | meaning
//   IDLE   | ready for a command
//   LOW    | low-nibble ALU pass
//   HIGH   | high-nibble ALU pass (wide only)
//   DONE   | results visible, done pulse
module alu_seq (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef ALU_SEQ_WIDE_EN
    localparam logic WIDE_EN = 1'b1;
`else
    localparam logic WIDE_EN = 1'b0;
`endif

    logic [1:0] state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic       zero_q, zero_d;
    logic       carry_q, carry_d;
    logic       sign_q, sign_d;
    logic [2:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic       cin_q, cin_d;
    logic       wide_q, wide_d;
    logic       lo_zero_q, lo_zero_d;
    logic       lo_carry_q, lo_carry_d;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_ci;
    logic [2:0] alu_op;
    logic       accept;
    logic       cmd_wide_eff;

    assign accept       = bus.cmd_valid && (state_q == S_IDLE);
    assign cmd_wide_eff = bus.cmd_wide & WIDE_EN;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        sign_d     = sign_q;
        op_d       = op_q;
        data_d     = data_q;
        cin_d      = cin_q;
        wide_d     = wide_q;
        lo_zero_d  = lo_zero_q;
        lo_carry_d = lo_carry_q;
        alu_a      = 4'h0;
        alu_b      = 4'h0;
        alu_ci     = 1'b0;
        alu_op     = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.cmd_op;
                    data_d = bus.cmd_data;
                    cin_d  = bus.cmd_cin;
                    wide_d = cmd_wide_eff;
                    if (bus.cmd_load) begin
                        // loads bypass the ALU, so acc is written on the accept edge
                        if (cmd_wide_eff) begin
                            acc_d = bus.cmd_data;
                        end else begin
                            acc_d[3:0] = bus.cmd_data[3:0];
                        end
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOW;
                    end
                end
            end
            S_LOW: begin
                alu_a      = acc_q[3:0];
                alu_b      = data_q[3:0];
                alu_ci     = cin_q;
                alu_op     = op_q;
                acc_d[3:0] = bus.alu_R;
                lo_zero_d  = bus.alu_zero;
                lo_carry_d = bus.alu_carry;
                if (wide_q) begin
                    state_d = S_HIGH;
                end else begin
                    zero_d  = bus.alu_zero;
                    carry_d = bus.alu_carry;
                    sign_d  = bus.alu_sign;
                    state_d = S_DONE;
                end
            end
            S_HIGH: begin
                alu_a      = acc_q[7:4];
                alu_b      = data_q[7:4];
                // logic ops (op[2]=1) take the command carry; arithmetic chains the low carry
                alu_ci     = op_q[2] ? cin_q : lo_carry_q;
                alu_op     = op_q;
                acc_d[7:4] = bus.alu_R;
                zero_d     = lo_zero_q & bus.alu_zero;
                carry_d    = bus.alu_carry;
                sign_d     = bus.alu_R[3];
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= 8'h00;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            sign_q     <= 1'b0;
            op_q       <= 3'b000;
            data_q     <= 8'h00;
            cin_q      <= 1'b0;
            wide_q     <= 1'b0;
            lo_zero_q  <= 1'b0;
            lo_carry_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            sign_q     <= sign_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cin_q      <= cin_d;
            wide_q     <= wide_d;
            lo_zero_q  <= lo_zero_d;
            lo_carry_q <= lo_carry_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.acc       = acc_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.sign      = sign_q;
    assign bus.alu_A     = alu_a;
    assign bus.alu_B     = alu_b;
    assign bus.alu_cin   = alu_ci;
    assign bus.alu_Op    = alu_op;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU, word-level accumulator model, directed and random commands.
module tb_alu_seq;

`ifdef ALU_SEQ_WIDE_EN
    localparam bit WIDE_EN_TB = 1'b1;
`else
    localparam bit WIDE_EN_TB = 1'b0;
`endif

    logic clk;
    logic reset;
    alu_seq_if bus ();

    alu_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // external ALU: op[2]=0 adds with carry, op[2]=1 is bitwise AND
    logic [4:0] alu_sum;
    logic [3:0] alu_r;
    logic       alu_c;
    always_comb begin
        alu_sum = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + {4'b0, bus.alu_cin};
        alu_r   = alu_sum[3:0];
        alu_c   = alu_sum[4];
        if (bus.alu_Op[2]) begin
            alu_r = bus.alu_A & bus.alu_B;
            alu_c = 1'b0;
        end
        bus.alu_R     = alu_r;
        bus.alu_zero  = (alu_r == 4'h0);
        bus.alu_carry = alu_c;
        bus.alu_sign  = alu_r[3];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_acc;
    logic        m_zero, m_carry, m_sign;
    int          exp_lat;
    logic [11:0] exp_drv [3];

    logic [3:0]  cap_done;
    logic [3:0]  cap_rdy;
    logic [11:0] cap_drv [4];
    logic [10:0] cap_res [4];

    task automatic model_reset();
        m_acc = 8'h00; m_zero = 1'b0; m_carry = 1'b0; m_sign = 1'b0;
    endtask

    // Word-level reference: exp_drv holds the ALU drive expected in cycles 1..3 after accept.
    task automatic model_cmd(input logic [2:0] op, input logic [7:0] data,
                             input logic cin, input logic wide, input logic load);
        logic       w;
        logic [4:0] lo;
        logic [8:0] full;
        logic [3:0] r;
        w = wide && WIDE_EN_TB;
        for (int i = 0; i < 3; i++) exp_drv[i] = 12'h000;
        lo = {1'b0, m_acc[3:0]} + {1'b0, data[3:0]} + {4'b0, cin};
        if (load) begin
            exp_lat = 1;
            if (w) m_acc = data;
            else   m_acc[3:0] = data[3:0];
        end else if (!w) begin
            exp_lat    = 2;
            exp_drv[0] = {op, cin, m_acc[3:0], data[3:0]};
            r          = op[2] ? (m_acc[3:0] & data[3:0]) : lo[3:0];
            m_carry    = op[2] ? 1'b0 : lo[4];
            m_acc[3:0] = r;
            m_zero     = (r == 4'h0);
            m_sign     = r[3];
        end else begin
            exp_lat    = 3;
            exp_drv[0] = {op, cin, m_acc[3:0], data[3:0]};
            exp_drv[1] = {op, (op[2] ? cin : lo[4]), m_acc[7:4], data[7:4]};
            if (op[2]) begin
                m_acc   = m_acc & data;
                m_carry = 1'b0;
            end else begin
                full    = {1'b0, m_acc} + {1'b0, data} + {8'b0, cin};
                m_acc   = full[7:0];
                m_carry = full[8];
            end
            m_zero = (m_acc == 8'h00);
            m_sign = m_acc[7];
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Waits for ready, issues one command, then records four cycles of outputs.
    task automatic issue(input logic [2:0] op, input logic [7:0] data,
                         input logic cin, input logic wide, input logic load);
        int waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL issue_ready_timeout: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, waited);
        end
        bus.cmd_op = op; bus.cmd_data = data; bus.cmd_cin = cin;
        bus.cmd_wide = wide; bus.cmd_load = load; bus.cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cap_done[k] = bus.done;
            cap_rdy[k]  = bus.cmd_ready;
            cap_drv[k]  = {bus.alu_Op, bus.alu_cin, bus.alu_A, bus.alu_B};
            cap_res[k]  = {bus.acc, bus.zero, bus.carry, bus.sign};
            if (k == 0) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op    = 3'($urandom);
                bus.cmd_data  = 8'($urandom);
                bus.cmd_cin   = 1'($urandom);
                bus.cmd_wide  = 1'($urandom);
                bus.cmd_load  = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        bus.cmd_op = 3'b000; bus.cmd_data = 8'h00; bus.cmd_cin = 1'b0;
        bus.cmd_wide = 1'b0; bus.cmd_load = 1'b0;
        reset = 1'b1; bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.acc, bus.zero, bus.carry, bus.sign, bus.done} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: acc/z/c/s/done=%h required 000", {bus.acc, bus.zero, bus.carry, bus.sign, bus.done});
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%0b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_narrow_add();
        do_reset();
        model_cmd(3'b000, 8'h03, 1'b0, 1'b0, 1'b1);
        issue(3'b000, 8'h03, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (cap_done !== 4'b0001 || cap_res[0][10:3] !== 8'h03) begin
            n_fail++;
            $display("FAIL narrow_load: done=%b acc=%h required 0001 03", cap_done, cap_res[0][10:3]);
        end
        model_cmd(3'b000, 8'h05, 1'b0, 1'b0, 1'b0);
        issue(3'b000, 8'h05, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (cap_done !== 4'b0010) begin
            n_fail++;
            $display("FAIL narrow_add_latency: done=%b required 0010", cap_done);
        end
        n_checks++;
        if (cap_res[1] !== {8'h08, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL narrow_add_result: acc/z/c/s=%h required %h", cap_res[1], {8'h08, 3'b001});
        end
        n_checks++;
        if (cap_drv[0] !== {3'b000, 1'b0, 4'h3, 4'h5} || cap_drv[1] !== 12'h000) begin
            n_fail++;
            $display("FAIL narrow_add_drive: low=%h done=%h required %h 000", cap_drv[0], cap_drv[1], {3'b000, 1'b0, 4'h3, 4'h5});
        end
    endtask

    task automatic test_wide();
        do_reset();
`ifdef ALU_SEQ_WIDE_EN
        model_cmd(3'b000, 8'h0F, 1'b0, 1'b1, 1'b1);
        issue(3'b000, 8'h0F, 1'b0, 1'b1, 1'b1);
        model_cmd(3'b000, 8'h01, 1'b0, 1'b1, 1'b0);
        issue(3'b000, 8'h01, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cap_done !== 4'b0100 || cap_res[2] !== {8'h10, 3'b000}) begin
            n_fail++;
            $display("FAIL wide_carry_chain: done=%b acc/z/c/s=%h required 0100 %h", cap_done, cap_res[2], {8'h10, 3'b000});
        end
        n_checks++;
        if (cap_drv[1] !== {3'b000, 1'b1, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL wide_high_drive: %h required %h", cap_drv[1], {3'b000, 1'b1, 4'h0, 4'h0});
        end
        model_cmd(3'b000, 8'hFF, 1'b0, 1'b1, 1'b1);
        issue(3'b000, 8'hFF, 1'b0, 1'b1, 1'b1);
        model_cmd(3'b000, 8'h01, 1'b0, 1'b1, 1'b0);
        issue(3'b000, 8'h01, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cap_res[2] !== {8'h00, 3'b110}) begin
            n_fail++;
            $display("FAIL wide_wrap: acc/z/c/s=%h required %h", cap_res[2], {8'h00, 3'b110});
        end
`else
        model_cmd(3'b000, 8'hAB, 1'b0, 1'b1, 1'b1);
        issue(3'b000, 8'hAB, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (cap_res[0][10:3] !== 8'h0B) begin
            n_fail++;
            $display("FAIL narrow_build_load: acc=%h required 0b", cap_res[0][10:3]);
        end
        model_cmd(3'b000, 8'h01, 1'b0, 1'b1, 1'b0);
        issue(3'b000, 8'h01, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cap_done !== 4'b0010 || cap_res[1][10:3] !== 8'h0C) begin
            n_fail++;
            $display("FAIL narrow_build_wide_add: done=%b acc=%h required 0010 0c", cap_done, cap_res[1][10:3]);
        end
        n_checks++;
        if (cap_drv[1] !== 12'h000 || cap_drv[2] !== 12'h000) begin
            n_fail++;
            $display("FAIL narrow_build_no_high: drive=%h %h required 000 000", cap_drv[1], cap_drv[2]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0]  rdy_v, done_v;
        logic [10:0] res_a, res_b, exp_a, exp_b;
        do_reset();
        model_cmd(3'b000, 8'h05, 1'b1, 1'b0, 1'b0);
        exp_a = {m_acc, m_zero, m_carry, m_sign};
        model_cmd(3'b100, 8'h03, 1'b0, 1'b0, 1'b0);
        exp_b = {m_acc, m_zero, m_carry, m_sign};
        @(negedge clk);
        bus.cmd_op = 3'b000; bus.cmd_data = 8'h05; bus.cmd_cin = 1'b1;
        bus.cmd_wide = 1'b0; bus.cmd_load = 1'b0; bus.cmd_valid = 1'b1;
        res_a = '0; res_b = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rdy_v[k-1]  = bus.cmd_ready;
            done_v[k-1] = bus.done;
            if (k == 2) res_a = {bus.acc, bus.zero, bus.carry, bus.sign};
            if (k == 5) res_b = {bus.acc, bus.zero, bus.carry, bus.sign};
            if (k == 1) begin
                bus.cmd_op = 3'b100; bus.cmd_data = 8'h03; bus.cmd_cin = 1'b0;
            end
            if (k == 4) bus.cmd_valid = 1'b0;
        end
        n_checks++;
        if (rdy_v !== 6'b100100) begin
            n_fail++;
            $display("FAIL b2b_ready: %b required 100100", rdy_v);
        end
        n_checks++;
        if (done_v !== 6'b010010) begin
            n_fail++;
            $display("FAIL b2b_done: %b required 010010", done_v);
        end
        n_checks++;
        if (res_a !== exp_a || res_b !== exp_b) begin
            n_fail++;
            $display("FAIL b2b_result: %h %h required %h %h", res_a, res_b, exp_a, exp_b);
        end
    endtask

    task automatic test_reset_abort();
        int seen_done = 0;
        do_reset();
        model_cmd(3'b000, 8'h0F, 1'b0, 1'b1, 1'b1);
        issue(3'b000, 8'h0F, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        bus.cmd_op = 3'b000; bus.cmd_data = 8'h01; bus.cmd_cin = 1'b0;
        bus.cmd_wide = 1'b1; bus.cmd_load = 1'b0; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (WIDE_EN_TB) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        n_checks++;
        if ({bus.acc, bus.zero, bus.carry, bus.sign, bus.done, bus.cmd_ready} !== 13'h001) begin
            n_fail++;
            $display("FAIL abort_state: acc/z/c/s/done/ready=%h required 0001", {bus.acc, bus.zero, bus.carry, bus.sign, bus.done, bus.cmd_ready});
        end
        bus.cmd_data = 8'h55; bus.cmd_load = 1'b1; bus.cmd_wide = 1'b0; bus.cmd_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        n_checks++;
        if (seen_done != 0 || bus.acc !== 8'h00 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done: done_pulses=%0d acc=%h ready=%0b required 0 00 1", seen_done, bus.acc, bus.cmd_ready);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] data;
        logic       cin, wide, load;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op   = 3'($urandom_range(0, 7));
            data = 8'($urandom);
            cin  = 1'($urandom);
            wide = 1'($urandom);
            load = ($urandom_range(0, 3) == 0);
            model_cmd(op, data, cin, wide, load);
            issue(op, data, cin, wide, load);
            n_checks++;
            if (cap_done !== (4'b0001 << (exp_lat - 1))) begin
                n_fail++;
                $display("FAIL rand_done[%0d]: %b required %b", i, cap_done, 4'b0001 << (exp_lat - 1));
            end
            n_checks++;
            if (cap_rdy !== (4'b1111 << exp_lat)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: %b required %b", i, cap_rdy, 4'b1111 << exp_lat);
            end
            n_checks++;
            if ({cap_drv[2], cap_drv[1], cap_drv[0]} !== {exp_drv[2], exp_drv[1], exp_drv[0]}) begin
                n_fail++;
                $display("FAIL rand_drive[%0d]: %h required %h", i, {cap_drv[2], cap_drv[1], cap_drv[0]}, {exp_drv[2], exp_drv[1], exp_drv[0]});
            end
            n_checks++;
            if (cap_res[exp_lat - 1] !== {m_acc, m_zero, m_carry, m_sign}) begin
                n_fail++;
                $display("FAIL rand_result[%0d] op=%0d wide=%0b load=%0b: %h required %h", i, op, wide, load, cap_res[exp_lat - 1], {m_acc, m_zero, m_carry, m_sign});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        model_reset();
        test_reset();
        test_narrow_add();
        test_wide();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
